// File: rtl/rng_pkg.sv
// Shared constants, types and the round-robin pick function for the
// xorwow random-word arbiter.
package rng_pkg;

  localparam int MAX_REQ = 8;

  localparam logic [31:0] INIT_X   = 32'd123456789;
  localparam logic [31:0] INIT_Y   = 32'd362436069;
  localparam logic [31:0] INIT_Z   = 32'd521288629;
  localparam logic [31:0] INIT_W   = 32'd88675123;
  localparam logic [31:0] INIT_V   = 32'd5783321;
  localparam logic [31:0] INIT_D   = 32'd6615241;
  localparam logic [31:0] D_STRIDE = 32'd362437;

  typedef enum logic [1:0] {
    FILL_T,
    FILL_UPD,
    FILL_OUT,
    SERVE
  } fsm_state_e;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] w;
    logic [31:0] v;
    logic [31:0] d;
    logic [31:0] t;
  } gen_state_t;

  localparam gen_state_t GEN_INIT = '{
    x: INIT_X, y: INIT_Y, z: INIT_Z, w: INIT_W,
    v: INIT_V, d: INIT_D, t: 32'd0
  };

  // First set bit scanning upward from ptr+1, wrapping modulo num_req.
  // Scanning offsets from largest to smallest lets the nearest hit win.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0]         ptr,
                                         input int                 num_req);
    int         idx;
    logic [2:0] idx3;
    rr_pick = ptr;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= num_req) begin
        idx  = (int'(ptr) + k) % num_req;
        idx3 = 3'(idx);
        if (req[idx3]) rr_pick = idx3;
      end
    end
  endfunction

endpackage

// File: rtl/rng_rr_picker.sv
// Combinational round-robin winner selection over the request vector.
module rng_rr_picker
  import rng_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  logic [MAX_REQ-1:0] req_ext;
  logic [2:0]         ptr_ext;
  logic [2:0]         pick;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    ptr_ext                = 3'(ptr);
    pick                   = rr_pick(req_ext, ptr_ext, NUM_REQ);
    winner                 = IDX_W'(pick);
    any_req                = |req;
  end

endmodule

// File: rtl/rng_arbiter.sv
// One xorwow generator with a one-word prefetch buffer, refilled in three
// phases and handed out round-robin to NUM_REQ requesters.
module rng_arbiter
  import rng_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               reseed,
  input  logic [31:0]        seed_in,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic [31:0]        rand_out,
  output logic               rand_valid,
  output logic               busy
);

  localparam logic [IDX_W-1:0] RR_RESET = IDX_W'(NUM_REQ - 1);

  fsm_state_e         state_q, state_d;
  gen_state_t         gen_q, gen_d;
  logic [31:0]        word_q, word_d;
  logic               word_valid_q, word_valid_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [31:0]        rand_out_q, rand_out_d;
  logic               rand_valid_q, rand_valid_d;
  logic               busy_q, busy_d;

  logic [IDX_W-1:0]   winner;
  logic               any_req;

  rng_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req     (req),
    .ptr     (rr_ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    // NOTE: every signal gets its hold/idle value first, so no branch can leave one unassigned and infer a latch.
    state_d      = state_q;
    gen_d        = gen_q;
    word_d       = word_q;
    word_valid_d = word_valid_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_d        = '0;
    gnt_idx_d    = '0;
    rand_out_d   = rand_out_q;
    rand_valid_d = 1'b0;

    if (reseed) begin
      // Reseed wins over everything, including a grant in SERVE.
      gen_d        = GEN_INIT;
      gen_d.x      = INIT_X ^ seed_in;
      word_valid_d = 1'b0;
      state_d      = FILL_T;
    end else begin
      unique case (state_q)
        FILL_T: begin
          gen_d.t = gen_q.x ^ (gen_q.x >> 2);
          state_d = FILL_UPD;
        end
        FILL_UPD: begin
          gen_d.x = gen_q.y;
          gen_d.y = gen_q.z;
          gen_d.z = gen_q.w;
          gen_d.w = gen_q.v;
          gen_d.v = (gen_q.v ^ (gen_q.v << 4)) ^ (gen_q.t ^ (gen_q.t << 1));
          gen_d.d = gen_q.d + D_STRIDE;
          state_d = FILL_OUT;
        end
        FILL_OUT: begin
          word_d       = gen_q.d + gen_q.v;
          word_valid_d = 1'b1;
          state_d      = SERVE;
        end
        SERVE: begin
          if (any_req) begin
            gnt_d        = NUM_REQ'(1) << winner;
            gnt_idx_d    = winner;
            rand_out_d   = word_q;
            rand_valid_d = 1'b1;
            rr_ptr_d     = winner;
            word_valid_d = 1'b0;
            state_d      = FILL_T;
          end
        end
        default: state_d = FILL_T;
      endcase
    end

    busy_d = ~word_valid_d;
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FILL_T;
      gen_q        <= GEN_INIT;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      rr_ptr_q     <= RR_RESET;
      gnt_q        <= '0;
      gnt_idx_q    <= '0;
      rand_out_q   <= '0;
      rand_valid_q <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      gen_q        <= gen_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_q        <= gnt_d;
      gnt_idx_q    <= gnt_idx_d;
      rand_out_q   <= rand_out_d;
      rand_valid_q <= rand_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign gnt        = gnt_q;
  assign gnt_idx    = gnt_idx_q;
  assign rand_out   = rand_out_q;
  assign rand_valid = rand_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_rng_arbiter.sv
// Self-checking bench for rng_arbiter against a C-style xorwow model and a
// round-robin pick model.
module tb_rng_arbiter;

  localparam int N = 4;
  localparam logic [31:0] FIRST_WORD = 32'h0EB70507;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic         reseed;
  logic [31:0]  seed_in;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_idx;
  logic [31:0]  rand_out;
  logic         rand_valid;
  logic         busy;

  int checks = 0;
  int errors = 0;

  // Reference model state: xorwow registers and last granted index.
  logic [31:0] mx, my, mz, mw, mv, md;
  int          mrr;

  rng_arbiter #(.NUM_REQ(N), .IDX_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .reseed     (reseed),
    .seed_in    (seed_in),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx),
    .rand_out   (rand_out),
    .rand_valid (rand_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_seed(input logic [31:0] s);
    mx = 32'd123456789 ^ s;
    my = 32'd362436069;
    mz = 32'd521288629;
    mw = 32'd88675123;
    mv = 32'd5783321;
    md = 32'd6615241;
  endtask

  function automatic logic [31:0] model_next();
    logic [31:0] t;
    t  = mx ^ (mx >> 2);
    mx = my;
    my = mz;
    mz = mw;
    mw = mv;
    mv = (mv ^ (mv << 4)) ^ (t ^ (t << 1));
    md = md + 32'd362437;
    return md + mv;
  endfunction

  function automatic int model_pick(input logic [N-1:0] r);
    int w;
    w = -1;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (mrr + k) % N;
      if (r[2'(idx)] && w < 0) w = idx;
    end
    if (w >= 0) mrr = w;
    return w;
  endfunction

  task automatic wait_grant(input string tag, output int cycles);
    cycles = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (rand_valid === 1'b1) begin
        cycles = i;
        break;
      end
    end
    checks++;
    if (cycles == 0) begin
      errors++;
      $display("FAIL %s_timeout: no grant within 40 cycles", tag);
    end
  endtask

  task automatic release_reset();
    #2 rst = 1'b1;
    model_seed(32'd0);
    mrr = N - 1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = '0; reseed = 1'b0; seed_in = '0;
    step(); step();
    checks++; if (gnt !== '0)        begin errors++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
    checks++; if (gnt_idx !== 2'd0)  begin errors++; $display("FAIL rst_gnt_idx: got %0d want 0", gnt_idx); end
    checks++; if (rand_out !== '0)   begin errors++; $display("FAIL rst_rand_out: got %h want 0", rand_out); end
    checks++; if (rand_valid !== 0)  begin errors++; $display("FAIL rst_rand_valid: got %b want 0", rand_valid); end
    checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL rst_busy: got %b want 1", busy); end
    release_reset();
  endtask

  task automatic test_first_grant();
    logic [31:0] exp_word;
    int          exp_idx;
    req = 4'b0001;
    for (int e = 1; e <= 3; e++) begin
      step();
      checks++; if (rand_valid !== 1'b0) begin errors++; $display("FAIL first_early_valid[%0d]: got %b want 0", e, rand_valid); end
      checks++; if (busy !== (e < 3))     begin errors++; $display("FAIL first_busy[%0d]: got %b want %b", e, busy, e < 3); end
    end
    step();
    exp_word = model_next();
    exp_idx  = model_pick(req);
    checks++; if (rand_valid !== 1'b1)    begin errors++; $display("FAIL first_valid: got %b want 1", rand_valid); end
    checks++; if (gnt !== 4'b0001)        begin errors++; $display("FAIL first_gnt: got %b want 0001", gnt); end
    checks++; if (gnt_idx !== 2'(exp_idx)) begin errors++; $display("FAIL first_idx: got %0d want %0d", gnt_idx, exp_idx); end
    checks++; if (rand_out !== FIRST_WORD) begin errors++; $display("FAIL first_word_const: got %h want %h", rand_out, FIRST_WORD); end
    checks++; if (rand_out !== exp_word)  begin errors++; $display("FAIL first_word_model: got %h want %h", rand_out, exp_word); end
    checks++; if (busy !== 1'b1)          begin errors++; $display("FAIL first_busy_after: got %b want 1", busy); end
    req = '0;
    step();
    checks++; if (rand_valid !== 1'b0 || gnt !== '0) begin errors++; $display("FAIL first_pulse: valid %b gnt %b want 0/0000", rand_valid, gnt); end
    checks++; if (rand_out !== FIRST_WORD) begin errors++; $display("FAIL first_hold: got %h want %h", rand_out, FIRST_WORD); end
  endtask

  task automatic test_fairness();
    int cyc, exp_idx;
    logic [31:0] exp_word;
    req = 4'b1111;
    for (int g = 0; g < 16; g++) begin
      wait_grant("fair", cyc);
      exp_idx  = model_pick(req);
      exp_word = model_next();
      if (g > 0) begin
        checks++; if (cyc != 4) begin errors++; $display("FAIL fair_gap[%0d]: got %0d want 4", g, cyc); end
      end
      checks++; if (gnt_idx !== 2'(exp_idx)) begin errors++; $display("FAIL fair_idx[%0d]: got %0d want %0d", g, gnt_idx, exp_idx); end
      checks++; if (gnt !== (N'(1) << exp_idx)) begin errors++; $display("FAIL fair_gnt[%0d]: got %b want idx %0d", g, gnt, exp_idx); end
      checks++; if (rand_out !== exp_word) begin errors++; $display("FAIL fair_word[%0d]: got %h want %h", g, rand_out, exp_word); end
    end
    req = '0;
  endtask

  task automatic test_random();
    int cyc, exp_idx, gap;
    logic [N-1:0] pat;
    logic [31:0]  exp_word;
    for (int g = 0; g < 12; g++) begin
      gap = $urandom_range(0, 3);
      for (int i = 0; i < gap; i++) step();
      pat = N'($urandom_range(1, 15));
      req = pat;
      wait_grant("rand", cyc);
      exp_idx  = model_pick(pat);
      exp_word = model_next();
      checks++; if (gnt_idx !== 2'(exp_idx)) begin errors++; $display("FAIL rand_idx[%0d]: req %b got %0d want %0d", g, pat, gnt_idx, exp_idx); end
      checks++; if (rand_out !== exp_word) begin errors++; $display("FAIL rand_word[%0d]: got %h want %h", g, rand_out, exp_word); end
      req = '0;
    end
  endtask

  task automatic test_idle();
    int          exp_idx;
    logic        idle_bad;
    logic [31:0] exp_word;
    req = '0;
    repeat (10) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_full: busy %b want 0", busy); end
    idle_bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (rand_valid !== 1'b0 || busy !== 1'b0) idle_bad = 1'b1;
    end
    checks++; if (idle_bad) begin errors++; $display("FAIL idle_hold: grant or busy seen while idle, want none"); end
    req = 4'b0100;
    step();
    exp_idx  = model_pick(req);
    exp_word = model_next();
    checks++; if (rand_valid !== 1'b1 || gnt !== 4'b0100) begin errors++; $display("FAIL idle_gnt: valid %b gnt %b want 1/0100", rand_valid, gnt); end
    checks++; if (gnt_idx !== 2'(exp_idx)) begin errors++; $display("FAIL idle_idx: got %0d want %0d", gnt_idx, exp_idx); end
    checks++; if (rand_out !== exp_word) begin errors++; $display("FAIL idle_word: got %h want %h", rand_out, exp_word); end
    req = '0;
  endtask

  task automatic test_reseed_fill();
    int          cyc, exp_idx;
    logic [31:0] exp_word;
    req = 4'b0001;
    wait_grant("rsf_pre", cyc);
    exp_idx  = model_pick(req);
    exp_word = model_next();
    checks++; if (rand_out !== exp_word) begin errors++; $display("FAIL rsf_pre_word: got %h want %h", rand_out, exp_word); end
    req = '0;
    step();
    reseed = 1'b1; seed_in = 32'd0;
    step();
    reseed = 1'b0;
    model_seed(32'd0);
    checks++; if (busy !== 1'b1 || rand_valid !== 1'b0) begin errors++; $display("FAIL rsf_after: busy %b valid %b want 1/0", busy, rand_valid); end
    req = 4'b0001;
    wait_grant("rsf_zero", cyc);
    exp_idx  = model_pick(req);
    exp_word = model_next();
    checks++; if (rand_out !== FIRST_WORD) begin errors++; $display("FAIL rsf_zero_word: got %h want %h", rand_out, FIRST_WORD); end
    checks++; if (rand_out !== exp_word) begin errors++; $display("FAIL rsf_zero_model: got %h want %h", rand_out, exp_word); end
    req = '0;
    reseed = 1'b1; seed_in = 32'hDEADBEEF;
    step();
    reseed = 1'b0;
    model_seed(32'hDEADBEEF);
    for (int g = 0; g < 2; g++) begin
      req = 4'b0001;
      wait_grant("rsf_beef", cyc);
      exp_idx  = model_pick(req);
      exp_word = model_next();
      checks++; if (rand_out !== exp_word) begin errors++; $display("FAIL rsf_beef_word[%0d]: got %h want %h", g, rand_out, exp_word); end
      req = '0;
    end
  endtask

  task automatic test_reseed_vs_req();
    int          cyc, exp_idx;
    logic [31:0] exp_word, s;
    req = '0;
    for (int i = 0; i < 10 && busy !== 1'b0; i++) step();
    s = $urandom;
    reseed = 1'b1; seed_in = s; req = 4'b0010;
    step();
    reseed = 1'b0;
    model_seed(s);
    checks++; if (rand_valid !== 1'b0 || gnt !== '0) begin errors++; $display("FAIL rvr_nogrant: valid %b gnt %b want 0/0000", rand_valid, gnt); end
    wait_grant("rvr", cyc);
    exp_idx  = model_pick(req);
    exp_word = model_next();
    checks++; if (gnt_idx !== 2'(exp_idx)) begin errors++; $display("FAIL rvr_idx: got %0d want %0d", gnt_idx, exp_idx); end
    checks++; if (rand_out !== exp_word) begin errors++; $display("FAIL rvr_word: got %h want %h", rand_out, exp_word); end
    req = '0;
  endtask

  task automatic test_async_reset();
    int cyc, exp_idx;
    req = 4'b1000;
    wait_grant("async_a", cyc);
    exp_idx = model_pick(req);
    checks++; if (gnt_idx !== 2'(exp_idx)) begin errors++; $display("FAIL async_pre_idx: got %0d want %0d", gnt_idx, exp_idx); end
    #3 rst = 1'b0;
    #1;
    checks++; if (gnt !== '0 || rand_valid !== 1'b0) begin errors++; $display("FAIL async_a_gnt: gnt %b valid %b want 0000/0", gnt, rand_valid); end
    checks++; if (gnt_idx !== 2'd0 || rand_out !== '0) begin errors++; $display("FAIL async_a_data: idx %0d word %h want 0/0", gnt_idx, rand_out); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL async_a_busy: got %b want 1", busy); end
    req = '0;
    step(); step();
    release_reset();
    for (int i = 0; i < 10 && busy !== 1'b0; i++) step();
    req = 4'b1000;
    #3 rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b1 || rand_valid !== 1'b0) begin errors++; $display("FAIL async_b: busy %b valid %b want 1/0", busy, rand_valid); end
    req = '0;
    step(); step();
    release_reset();
    req = 4'b0001;
    wait_grant("async_c", cyc);
    checks++; if (cyc != 4) begin errors++; $display("FAIL async_c_latency: got %0d want 4", cyc); end
    checks++; if (rand_out !== FIRST_WORD) begin errors++; $display("FAIL async_c_word: got %h want %h", rand_out, FIRST_WORD); end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_fairness();
    test_random();
    test_idle();
    test_reseed_fill();
    test_reseed_vs_req();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
